// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift execution stage:
//   - default operand / shift-amount widths
//   - shift opcode encodings
//   - decoded control struct and the opcode decoder used by shift_exec_stage
// Build option: SHIFT_SRL_EN -- when defined, opcode 2'b10 decodes to a
// logical right shift; when undefined it decodes as an illegal opcode.
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_SHAMT_WIDTH = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRA  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // Control for the combinational shifter plus the illegal-op marker.
    typedef struct packed {
        logic dir_right;  // 1: shift toward LSB, 0: shift toward MSB
        logic arith;      // 1: vacated MSBs take the operand sign bit
        logic illegal;    // opcode not supported in this build
    } shift_ctrl_t;

    function automatic shift_ctrl_t decode_op(input logic [1:0] op);
        shift_ctrl_t ctrl;
        ctrl.dir_right = 1'b0;
        ctrl.arith     = 1'b0;
        ctrl.illegal   = 1'b1;
        case (op)
            OP_SLL: begin
                ctrl.illegal = 1'b0;
            end
            OP_SRA: begin
                ctrl.dir_right = 1'b1;
                ctrl.arith     = 1'b1;
                ctrl.illegal   = 1'b0;
            end
            OP_SRL: begin
`ifdef SHIFT_SRL_EN
                ctrl.dir_right = 1'b1;
                ctrl.illegal   = 1'b0;
`else
                ctrl.illegal   = 1'b1;
`endif
            end
            OP_RSVD: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/shift_core.sv
// -----------------------------------------------------------------------------
// shift_core
// Purely combinational bidirectional logarithmic shifter.
// Ports:
//   operand   [DATA_WIDTH-1:0]   value to shift
//   shamt     [SHAMT_WIDTH-1:0]  unsigned shift amount
//   dir_right                    1: right shift, 0: left shift (zero fill)
//   arith                        right shifts only: fill with operand MSB
//   result    [DATA_WIDTH-1:0]   shifted value
// SHAMT_WIDTH must equal log2(DATA_WIDTH).
// -----------------------------------------------------------------------------
module shift_core
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SHAMT_WIDTH = DEFAULT_SHAMT_WIDTH
) (
    input  logic [DATA_WIDTH-1:0]  operand,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic                   dir_right,
    input  logic                   arith,
    output logic [DATA_WIDTH-1:0]  result
);

    logic                  fill_bit;
    logic [DATA_WIDTH-1:0] acc;
    logic [DATA_WIDTH-1:0] fill_mask;

    assign fill_bit = arith & operand[DATA_WIDTH-1];

    // One mux level per shamt bit, stepping by 1, 2, 4, ... positions.
    // For right shifts the vacated top bits are ORed in from a mask that
    // is all-ones above the shifted-down data when filling with the sign.
    always_comb begin
        acc       = operand;
        fill_mask = '0;
        for (int i = 0; i < SHAMT_WIDTH; i++) begin
            fill_mask = ~({DATA_WIDTH{1'b1}} >> (1 << i)) & {DATA_WIDTH{fill_bit}};
            if (shamt[i]) begin
                if (dir_right) begin
                    acc = (acc >> (1 << i)) | fill_mask;
                end else begin
                    acc = acc << (1 << i);
                end
            end
        end
        result = acc;
    end

endmodule

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
// Two-stage pipelined shift unit (S1 operand register, S2 result register)
// with valid/ready handshakes on both sides. Computes SLL and SRA, plus SRL
// when built with SHIFT_SRL_EN. Unsupported opcodes flow through the pipe
// with out_illegal=1 and a zero result.
// Ports:
//   clock, reset_n            clock, synchronous active-low reset
//   in_valid / in_ready       upstream handshake
//   in_opcode [1:0]           00 SLL, 01 SRA, 10 SRL (optional), 11 reserved
//   in_operand, in_shamt      shift operands
//   out_valid / out_ready     downstream handshake
//   out_result                shifted value (0 for illegal ops)
//   out_zero, out_neg         flags of out_result
//   out_illegal               opcode was unsupported
// Handshake: a transfer happens on a rising edge with valid && ready. in_ready
// depends only on pipeline state, never on in_valid; out_* hold steady while
// out_valid=1 and out_ready=0.
// Build option: SHIFT_SRL_EN enables the logical right shift on opcode 10.
// -----------------------------------------------------------------------------
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SHAMT_WIDTH = DEFAULT_SHAMT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_opcode,
    input  logic [DATA_WIDTH-1:0]  in_operand,
    input  logic [SHAMT_WIDTH-1:0] in_shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_result,
    output logic                   out_zero,
    output logic                   out_neg,
    output logic                   out_illegal
);

    // S1: captured request
    logic                   s1_valid_q,   s1_valid_d;
    logic [1:0]             s1_opcode_q,  s1_opcode_d;
    logic [DATA_WIDTH-1:0]  s1_operand_q, s1_operand_d;
    logic [SHAMT_WIDTH-1:0] s1_shamt_q,   s1_shamt_d;

    // S2: registered result and flags
    logic                   s2_valid_q,   s2_valid_d;
    logic [DATA_WIDTH-1:0]  s2_result_q,  s2_result_d;
    logic                   s2_zero_q,    s2_zero_d;
    logic                   s2_neg_q,     s2_neg_d;
    logic                   s2_illegal_q, s2_illegal_d;

    logic                   s1_adv;
    logic                   in_fire;
    logic                   s2_load;
    shift_ctrl_t            ctrl;
    logic [DATA_WIDTH-1:0]  core_result;
    logic [DATA_WIDTH-1:0]  final_result;

    assign ctrl = decode_op(s1_opcode_q);

    shift_core #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SHAMT_WIDTH (SHAMT_WIDTH)
    ) u_shift_core (
        .operand   (s1_operand_q),
        .shamt     (s1_shamt_q),
        .dir_right (ctrl.dir_right),
        .arith     (ctrl.arith),
        .result    (core_result)
    );

    assign final_result = ctrl.illegal ? '0 : core_result;

    always_comb begin
        // S1 may move forward whenever S2 is empty or being drained now,
        // which lets a full pipe keep accepting one op per cycle.
        s1_adv   = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || s1_adv;
        in_fire  = in_valid && in_ready;
        s2_load  = s1_valid_q && s1_adv;

        s1_valid_d   = in_fire || (s1_valid_q && !s1_adv);
        s1_opcode_d  = s1_opcode_q;
        s1_operand_d = s1_operand_q;
        s1_shamt_d   = s1_shamt_q;
        if (in_fire) begin
            s1_opcode_d  = in_opcode;
            s1_operand_d = in_operand;
            s1_shamt_d   = in_shamt;
        end

        s2_valid_d   = s2_load || (s2_valid_q && !out_ready);
        s2_result_d  = s2_result_q;
        s2_zero_d    = s2_zero_q;
        s2_neg_d     = s2_neg_q;
        s2_illegal_d = s2_illegal_q;
        if (s2_load) begin
            s2_result_d  = final_result;
            s2_zero_d    = (final_result == '0);
            s2_neg_d     = final_result[DATA_WIDTH-1];
            s2_illegal_d = ctrl.illegal;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_opcode_q  <= '0;
            s1_operand_q <= '0;
            s1_shamt_q   <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_zero_q    <= 1'b0;
            s2_neg_q     <= 1'b0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_opcode_q  <= s1_opcode_d;
            s1_operand_q <= s1_operand_d;
            s1_shamt_q   <= s1_shamt_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_zero_q    <= s2_zero_d;
            s2_neg_q     <= s2_neg_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_zero    = s2_zero_q;
    assign out_neg     = s2_neg_q;
    assign out_illegal = s2_illegal_q;

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Two-stage pipelined shift execution stage; directly feeds the ALU writeback path.
- Accepts an operand, a shift amount and an opcode over a valid/ready handshake.
- Computes SLL or SRA, and SRL when the optional feature is compiled in.
- Registers the result with zero/negative flags; full throughput of one op per cycle under backpressure.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, 5, shift amount width; must equal log2(DATA_WIDTH).

Ports:
- clock  input  1  single clock domain.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clock.
- in_valid  input  1  upstream presents an op.
- in_ready  output  1  stage can accept an op this cycle.
- in_opcode  input  2  shift opcode: 00 SLL, 01 SRA, 10 SRL (optional), 11 reserved.
- in_operand  input  DATA_WIDTH  value to shift.
- in_shamt  input  SHAMT_WIDTH  shift amount, unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  downstream consumes the result.
- out_result  output  DATA_WIDTH  shifted value.
- out_zero  output  1  out_result == 0.
- out_neg  output  1  out_result[DATA_WIDTH-1].
- out_illegal  output  1  opcode was unsupported; out_result forced to 0.

Behaviour:
- Reset: when reset_n is low at a clock edge, both stage valid bits clear. out_valid=0, out_result=0, out_zero=0, out_neg=0, out_illegal=0, in_ready=1 in the following cycle.
- Reset mid-operation discards all in-flight ops; no partial result is presented.
- Handshake:
  - Transfer occurs on a rising edge where valid && ready.
  - out_* must stay stable while out_valid=1 && out_ready=0.
  - in_ready must not depend on in_valid.
- Stage 1 (S1) register: captures opcode, operand and shamt on input transfer.
  - s1_adv = !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_adv.
- Stage 2 (S2, output) register: computes the shift from the S1 contents and loads when s1_valid && s1_adv.
  - s2_valid clears on an output transfer with no new load.
- Latency: 2 cycles from input transfer to out_valid, with no stall.
  - Throughput is 1 op/cycle when out_ready is held high.
  - Under a stall, holds up to 2 ops (S1 + S2) before in_ready drops.
  - Ordering is strictly preserved.
- Arithmetic:
  - SLL: zero fill.
  - SRA: replicate operand[DATA_WIDTH-1] into the vacated bits.
  - shamt=0 returns the operand unchanged for every legal opcode.
  - The shift is a log-depth mux chain of stages 1, 2, 4, 8, 16.
- Flags: computed from the final out_result, including the forced 0 on an illegal op (out_zero=1, out_neg=0 in that case).
- Simultaneous events: an output transfer and a new S1→S2 load in the same cycle replace S2 with no bubble. An input transfer in that same cycle refills S1.
- Illegal opcode: 11 always; 10 when SHIFT_SRL_EN is undefined. The op still flows through the pipeline with out_illegal=1.

Optional Feature:
- SHIFT_SRL_EN.
- Defined: opcode 10 performs a logical right shift with zero fill, and out_illegal=0 for it.
- Undefined: opcode 10 is illegal, out_result=0, out_illegal=1; no SRL datapath is synthesised.

Decomposition:
- Shared package (shift_pkg) holds:
  - opcode constants OP_SLL=2'b00, OP_SRA=2'b01, OP_SRL=2'b10, OP_RSVD=2'b11;
  - default widths DATA_WIDTH=32, SHAMT_WIDTH=5.
- One sub-module, shift_core: purely combinational bidirectional log shifter (operand, shamt, direction, arith fill). It is instantiated between S1 and S2; all sequencing and handshake logic stays in shift_exec_stage.

Test Plan:
- SRA, operand 0x80000000, shamt 4, out_ready=1 → 2 cycles later out_result=0xF8000000, out_neg=1, out_zero=0.
- SLL, operand 0x00000001, shamt 31 → 0x80000000, out_neg=1. Then SLL, operand 0x00000002, shamt 31 → 0x00000000, out_zero=1.
- Back-to-back: 4 ops on consecutive cycles with out_ready=1 → 4 results on consecutive cycles, in order, starting at cycle 2.
- Backpressure: out_ready=0 for 6 cycles, in_valid=1 continuously → exactly 2 ops accepted and in_ready=0 from the third cycle. Raising out_ready drains them in order with outputs stable during the stall.
- Opcode 11 (and 10 without SHIFT_SRL_EN), operand 0xFFFFFFFF → out_result=0, out_illegal=1, out_zero=1. With SHIFT_SRL_EN, SRL 0x80000000 by 1 → 0x40000000.
- Assert reset_n=0 for one cycle while both stages are valid → next cycle out_valid=0, in_ready=1, out_result=0; no stale op emerges afterwards.
